// File: rtl/gpio_io_periph.sv
// Purpose: board-side GPIO peripheral; binary->BCD 7-segment display plus debounced switch inputs.
// Latency: display valid 34 edges after a new gpio_out is seen; gpio_in follows sw after DB_CYCLES..DB_CYCLES+3 edges.
// Backpressure: none; gpio_out writes arriving mid-conversion are re-checked in IDLE, so the last write always shows.
module gpio_io_periph #(
    parameter int DB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] gpio_out,
    input  logic [17:0] sw,
    output logic [17:0] gpio_in,
    output logic [55:0] hex,
    output logic        busy,
    output logic        overflow
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nx;
    logic          pending;
    logic [31:0]   src;
    logic [31:0]   shown_val;
    logic [31:0]   bin_sr;
    logic [39:0]   bcd;
    logic [39:0]   bcd_adj;
    logic [4:0]    sh_cnt;
    logic          start;
    logic          ovf_nx;
    logic [55:0]   hex_nx;
    logic          blank;
    logic [3:0]    dig;

    logic [17:0]   s1, s2, s2_prev;
    logic [CW-1:0] cnt;

    // Active-low gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: each digit >= 5 gets +3 before the shift (no inter-digit carry possible).
    function automatic logic [39:0] add3(input logic [39:0] b);
        logic [39:0] r;
        r = b;
        for (int i = 0; i < 10; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign start   = (state == IDLE) && (pending || (gpio_out != shown_val));
    assign bcd_adj = add3(bcd);
    assign ovf_nx  = (bcd[39:32] != 8'd0);

    // Display FSM state register.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Display FSM next-state: IDLE -> 32 SHIFT edges -> one DONE edge -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (sh_cnt == 5'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Segment image of the finished BCD value, with leading-zero blanking and overflow dashes.
    always_comb begin
        hex_nx = '1;
        blank  = 1'b1;
        dig    = 4'd0;
        if (ovf_nx) begin
            hex_nx = {8{SEG_DASH}};
        end else begin
            for (int i = 7; i >= 0; i--) begin
                dig = bcd[4*i +: 4];
                if (dig != 4'd0 || i == 0) begin
                    blank = 1'b0;
                end
                hex_nx[7*i +: 7] = blank ? SEG_BLANK : seg7(dig);
            end
        end
    end

    // Conversion datapath and registered display outputs; hex only changes in DONE so no partial value shows.
    always_ff @(posedge clk) begin
        if (res) begin
            pending   <= 1'b1;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            hex       <= '1;
            src       <= '0;
            shown_val <= '0;
            bin_sr    <= '0;
            bcd       <= '0;
            sh_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src     <= gpio_out;
                        bin_sr  <= gpio_out;
                        bcd     <= '0;
                        sh_cnt  <= '0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj[38:0], bin_sr, 1'b0};
                    sh_cnt        <= sh_cnt + 5'd1;
                end
                DONE: begin
                    shown_val <= src;
                    overflow  <= ovf_nx;
                    hex       <= hex_nx;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Switch synchronizer and debounce; the s2 == s2_prev term stops a saturated counter
    // from passing through the very first sample of a new value.
    always_ff @(posedge clk) begin
        if (res) begin
            s1      <= '0;
            s2      <= '0;
            s2_prev <= '0;
            cnt     <= '0;
            gpio_in <= '0;
        end else begin
            s1      <= sw;
            s2      <= s1;
            s2_prev <= s2;
            if (s2 != s2_prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (cnt == CNT_MAX && s2 == s2_prev) begin
                gpio_in <= s2;
            end
        end
    end

endmodule
